// File: rtl/control_unit_pkg.sv
// Shared definitions for the control unit: instruction field positions, opcode map,
// FSM state type and small opcode classification helpers.
package control_unit_pkg;

    localparam int unsigned OPC_MSB = 15;
    localparam int unsigned OPC_LSB = 11;
    localparam int unsigned RD_MSB  = 10;
    localparam int unsigned RD_LSB  = 8;
    localparam int unsigned RS1_MSB = 7;
    localparam int unsigned RS1_LSB = 5;
    localparam int unsigned RS2_MSB = 4;
    localparam int unsigned RS2_LSB = 2;
    localparam int unsigned IMM_MSB = 4;
    localparam int unsigned IMM_LSB = 0;

    localparam logic [4:0] OP_NOP   = 5'h00;
    localparam logic [4:0] OP_ADD   = 5'h01;
    localparam logic [4:0] OP_SUB   = 5'h02;
    localparam logic [4:0] OP_AND   = 5'h03;
    localparam logic [4:0] OP_OR    = 5'h04;
    localparam logic [4:0] OP_XOR   = 5'h05;
    localparam logic [4:0] OP_NOT   = 5'h06;
    localparam logic [4:0] OP_SR    = 5'h07;
    localparam logic [4:0] OP_SL    = 5'h08;
    localparam logic [4:0] OP_ANDI  = 5'h09;
    localparam logic [4:0] OP_ADDI  = 5'h0A;
    localparam logic [4:0] OP_SRI   = 5'h0B;
    localparam logic [4:0] OP_SLI   = 5'h0C;
    localparam logic [4:0] OP_LOAD  = 5'h0D;
    localparam logic [4:0] OP_STORE = 5'h0E;
    localparam logic [4:0] OP_HALT  = 5'h1F;

    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_MEMORY    = 3'd3,
        S_WRITEBACK = 3'd4,
        S_HALT      = 3'd5
    } state_t;

    // Opcodes that proceed to EXECUTE; NOP, HALT and unused codes do not.
    function automatic logic is_exec_op(input logic [4:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_SR, OP_SL,
            OP_ANDI, OP_ADDI, OP_SRI, OP_SLI, OP_LOAD, OP_STORE: is_exec_op = 1'b1;
            default:                                             is_exec_op = 1'b0;
        endcase
    endfunction

    function automatic logic uses_imm(input logic [4:0] op);
        case (op)
            OP_ANDI, OP_ADDI, OP_SRI, OP_SLI, OP_LOAD, OP_STORE: uses_imm = 1'b1;
            default:                                             uses_imm = 1'b0;
        endcase
    endfunction

    // Memory instructions borrow the adder to form rs1 + imm.
    function automatic logic [4:0] alu_opcode(input logic [4:0] op);
        if (op == OP_LOAD || op == OP_STORE) alu_opcode = OP_ADD;
        else                                 alu_opcode = op;
    endfunction

endpackage

// File: rtl/control_unit_pc.sv
// Program counter: increments on request, wraps at the word boundary, holds while frozen.
module program_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inc_i,
    input  logic             freeze_i,
    output logic [WIDTH-1:0] pc_o
);

    logic [WIDTH-1:0] pc_q, pc_d;

    always_comb begin
        pc_d = pc_q;
        if (inc_i && !freeze_i) pc_d = pc_q + WIDTH'(1);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) pc_q <= '0;
        else       pc_q <= pc_d;
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/control_unit.sv
// Multi-cycle control unit: sequences fetch/decode/execute/memory/writeback over one
// memory port and strobes the ALU and register file; HALT stops the core until reset.
module control_unit
    import control_unit_pkg::*;
#(
    parameter int unsigned WORD_SIZE     = 16,
    parameter int unsigned REG_ADDR_BITS = 3
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [WORD_SIZE-1:0]     instr_in,
    input  logic                     mem_ready,
    output logic                     mem_read,
    output logic                     mem_write,
    output logic                     mem_addr_sel,
    output logic [WORD_SIZE-1:0]     pc_out,
    output logic [4:0]               opcode,
    output logic                     alu_enable,
    output logic [REG_ADDR_BITS-1:0] rs1_addr,
    output logic [REG_ADDR_BITS-1:0] rs2_addr,
    output logic [REG_ADDR_BITS-1:0] rd_addr,
    output logic [WORD_SIZE-1:0]     imm_out,
    output logic                     alu_src_imm,
    output logic                     reg_write,
    output logic                     wb_sel,
    output logic                     halted
);

    state_t               state_q, state_d;
    logic [WORD_SIZE-1:0] ir_q, ir_d;
    logic [4:0]           ir_op;
    logic                 is_load, is_store;
    logic                 pc_inc, pc_freeze;

    assign ir_op    = ir_q[OPC_MSB:OPC_LSB];
    assign is_load  = (ir_op == OP_LOAD);
    assign is_store = (ir_op == OP_STORE);

    assign opcode      = alu_opcode(ir_op);
    assign alu_src_imm = uses_imm(ir_op);
    assign rd_addr     = REG_ADDR_BITS'(ir_q[RD_MSB:RD_LSB]);
    assign rs1_addr    = REG_ADDR_BITS'(ir_q[RS1_MSB:RS1_LSB]);
    assign rs2_addr    = REG_ADDR_BITS'(ir_q[RS2_MSB:RS2_LSB]);
    assign imm_out     = WORD_SIZE'(ir_q[IMM_MSB:IMM_LSB]);
    assign pc_freeze   = (state_q == S_HALT);

    program_counter #(.WIDTH(WORD_SIZE)) u_pc (
        .clock    (clock),
        .reset    (reset),
        .inc_i    (pc_inc),
        .freeze_i (pc_freeze),
        .pc_o     (pc_out)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        ir_d         = ir_q;
        pc_inc       = 1'b0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        mem_addr_sel = 1'b0;
        alu_enable   = 1'b0;
        reg_write    = 1'b0;
        wb_sel       = 1'b0;
        halted       = 1'b0;
        case (state_q)
            S_FETCH: begin
                // Reset already forces FETCH; gating keeps the read request low while held.
                mem_read = !reset;
                if (mem_ready) begin
                    ir_d    = instr_in;
                    pc_inc  = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (ir_op == OP_HALT)       state_d = S_HALT;
                else if (is_exec_op(ir_op)) state_d = S_EXECUTE;
                else                        state_d = S_FETCH;
            end
            S_EXECUTE: begin
                alu_enable = 1'b1;
                state_d    = (is_load || is_store) ? S_MEMORY : S_WRITEBACK;
            end
            S_MEMORY: begin
                mem_addr_sel = 1'b1;
                mem_read     = is_load;
                mem_write    = is_store;
                if (mem_ready) state_d = is_load ? S_WRITEBACK : S_FETCH;
            end
            S_WRITEBACK: begin
                reg_write = 1'b1;
                wb_sel    = is_load;
                state_d   = S_FETCH;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: an instruction-level model queues the expected outputs
// of every cycle, a negedge process compares them, and literal checks pin key values.
module tb_control_unit;
    import control_unit_pkg::*;

    localparam int unsigned WS = 16;
    localparam int unsigned RB = 3;

    logic          clock     = 1'b0;
    logic          reset     = 1'b1;
    logic [WS-1:0] instr_in  = '0;
    logic          mem_ready = 1'b0;
    logic          mem_read, mem_write, mem_addr_sel;
    logic [WS-1:0] pc_out, imm_out;
    logic [4:0]    opcode;
    logic          alu_enable, alu_src_imm, reg_write, wb_sel, halted;
    logic [RB-1:0] rs1_addr, rs2_addr, rd_addr;

    control_unit #(.WORD_SIZE(WS), .REG_ADDR_BITS(RB)) dut (
        .clock        (clock),
        .reset        (reset),
        .instr_in     (instr_in),
        .mem_ready    (mem_ready),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_addr_sel (mem_addr_sel),
        .pc_out       (pc_out),
        .opcode       (opcode),
        .alu_enable   (alu_enable),
        .rs1_addr     (rs1_addr),
        .rs2_addr     (rs2_addr),
        .rd_addr      (rd_addr),
        .imm_out      (imm_out),
        .alu_src_imm  (alu_src_imm),
        .reg_write    (reg_write),
        .wb_sel       (wb_sel),
        .halted       (halted)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        mr, mw, sel, ae, rw, wbs, hlt;
        logic [15:0] pc;
        logic [15:0] ir;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_ae = 0, n_rw = 0, n_mr = 0, n_mw = 0;
    logic [15:0] m_pc     = '0;
    logic [15:0] m_ir     = '0;
    logic        m_halted = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, req, $time);
        end
    endtask

    function automatic logic [4:0] m_alu_op(input logic [15:0] ir);
        logic [4:0] op;
        op = ir[15:11];
        return (op == OP_LOAD || op == OP_STORE) ? OP_ADD : op;
    endfunction

    function automatic logic m_imm_src(input logic [15:0] ir);
        return ir[15:11] inside {OP_ANDI, OP_ADDI, OP_SRI, OP_SLI, OP_LOAD, OP_STORE};
    endfunction

    function automatic logic m_is_exec(input logic [4:0] op);
        return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_SR, OP_SL,
                          OP_ANDI, OP_ADDI, OP_SRI, OP_SLI, OP_LOAD, OP_STORE};
    endfunction

    function automatic logic [15:0] enc(input logic [4:0] op, input logic [2:0] rd,
                                        input logic [2:0] rs1, input logic [4:0] low);
        return {op, rd, rs1, low};
    endfunction

    // f = {mem_read, mem_write, mem_addr_sel, alu_enable, reg_write, wb_sel}
    task automatic push(input logic [5:0] f);
        exp_t e;
        {e.mr, e.mw, e.sel, e.ae, e.rw, e.wbs} = f;
        e.hlt = m_halted;
        e.pc  = m_pc;
        e.ir  = m_ir;
        exp_q.push_back(e);
    endtask

    task automatic idle_in();
        mem_ready = 1'b1;
        instr_in  = 16'($urandom);
    endtask

    task automatic stall_in();
        mem_ready = 1'b0;
        instr_in  = 16'($urandom);
    endtask

    task automatic exec_instr(input logic [15:0] instr, input int fw, input int mw);
        logic [4:0] op;
        logic       ld, st;
        op = instr[15:11];
        ld = (op == OP_LOAD);
        st = (op == OP_STORE);
        for (int i = 0; i < fw; i++) begin
            @(posedge clock); #1; stall_in(); push(6'b100000);
        end
        @(posedge clock); #1; mem_ready = 1'b1; instr_in = instr; push(6'b100000);
        m_ir = instr;
        m_pc = m_pc + 16'd1;
        @(posedge clock); #1; idle_in(); push(6'b000000);
        if (op == OP_HALT) begin
            m_halted = 1'b1;
            return;
        end
        if (!m_is_exec(op)) return;
        @(posedge clock); #1; idle_in(); push(6'b000100);
        if (ld || st) begin
            for (int i = 0; i < mw; i++) begin
                @(posedge clock); #1; stall_in(); push({ld, st, 1'b1, 3'b000});
            end
            @(posedge clock); #1; idle_in(); push({ld, st, 1'b1, 3'b000});
            if (st) return;
        end
        @(posedge clock); #1; idle_in(); push({4'b0000, 1'b1, ld});
    endtask

    task automatic halt_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock); #1; idle_in(); push(6'b000000);
        end
    endtask

    task automatic do_reset(input int fw);
        for (int i = 0; i < fw; i++) begin
            @(posedge clock); #1; stall_in(); push(6'b100000);
        end
        @(posedge clock); #1;
        stall_in();
        reset    = 1'b1;
        m_pc     = '0;
        m_ir     = '0;
        m_halted = 1'b0;
        push(6'b000000);
        #1;
        chk("reset_mem_read", 32'(mem_read), 32'd0);
        chk("reset_pc", 32'(pc_out), 32'd0);
        chk("reset_halted", 32'(halted), 32'd0);
        @(negedge clock); #1;
        reset = 1'b0;
        #1 chk("release_mem_read", 32'(mem_read), 32'd1);
    endtask

    // PC is forced between edges while FETCH is stalled, so no update races the deposit.
    task automatic preset_pc_ffff();
        @(posedge clock); #1; stall_in();
        force dut.u_pc.pc_q = 16'hFFFF;
        #1 release dut.u_pc.pc_q;
        m_pc = 16'hFFFF;
        push(6'b100000);
    endtask

    initial begin : compare
        exp_t e;
        forever begin
            @(negedge clock);
            if (alu_enable) n_ae++;
            if (reg_write)  n_rw++;
            if (mem_read)   n_mr++;
            if (mem_write)  n_mw++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("mem_read", 32'(mem_read), 32'(e.mr));
                chk("mem_write", 32'(mem_write), 32'(e.mw));
                chk("mem_addr_sel", 32'(mem_addr_sel), 32'(e.sel));
                chk("pc_out", 32'(pc_out), 32'(e.pc));
                chk("opcode", 32'(opcode), 32'(m_alu_op(e.ir)));
                chk("alu_enable", 32'(alu_enable), 32'(e.ae));
                chk("rd_addr", 32'(rd_addr), 32'(e.ir[10:8]));
                chk("rs1_addr", 32'(rs1_addr), 32'(e.ir[7:5]));
                chk("rs2_addr", 32'(rs2_addr), 32'(e.ir[4:2]));
                chk("imm_out", 32'(imm_out), 32'(e.ir[4:0]));
                chk("alu_src_imm", 32'(alu_src_imm), 32'(m_imm_src(e.ir)));
                chk("reg_write", 32'(reg_write), 32'(e.rw));
                chk("wb_sel", 32'(wb_sel), 32'(e.wbs));
                chk("halted", 32'(halted), 32'(e.hlt));
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int d_ae, d_rw, d_mr, d_mw;
        repeat (2) @(posedge clock);
        do_reset(0);

        d_ae = n_ae; d_rw = n_rw;
        exec_instr(enc(OP_ADD, 3'd3, 3'd1, {3'd2, 2'b00}), 0, 0);
        @(negedge clock); #1;
        chk("add_pc", 32'(pc_out), 32'd1);
        chk("add_opcode", 32'(opcode), 32'd1);
        chk("add_rd", 32'(rd_addr), 32'd3);
        chk("add_rs1", 32'(rs1_addr), 32'd1);
        chk("add_rs2", 32'(rs2_addr), 32'd2);
        chk("add_wb_sel", 32'(wb_sel), 32'd0);
        chk("add_ae_cycles", 32'(n_ae - d_ae), 32'd1);
        chk("add_rw_cycles", 32'(n_rw - d_rw), 32'd1);

        d_mr = n_mr;
        exec_instr(enc(OP_LOAD, 3'd2, 3'd1, 5'd5), 0, 0);
        @(negedge clock); #1;
        chk("load_wb_sel", 32'(wb_sel), 32'd1);
        chk("load_reg_write", 32'(reg_write), 32'd1);
        chk("load_opcode", 32'(opcode), 32'd1);
        chk("load_imm", 32'(imm_out), 32'd5);
        chk("load_src_imm", 32'(alu_src_imm), 32'd1);
        chk("load_mr_cycles", 32'(n_mr - d_mr), 32'd2);
        chk("load_pc", 32'(pc_out), 32'd2);

        d_mw = n_mw; d_rw = n_rw;
        exec_instr(enc(OP_STORE, 3'd0, 3'd4, 5'd17), 1, 3);
        @(negedge clock); #1;
        chk("store_mw_cycles", 32'(n_mw - d_mw), 32'd4);
        chk("store_rw_cycles", 32'(n_rw - d_rw), 32'd0);

        exec_instr(enc(OP_SUB,  3'd7, 3'd6, {3'd5, 2'b00}), 2, 0);
        exec_instr(enc(OP_ANDI, 3'd1, 3'd2, 5'd31), 0, 0);
        exec_instr(enc(OP_SLI,  3'd4, 3'd4, 5'd3), 1, 0);
        exec_instr(enc(OP_XOR,  3'd5, 3'd0, {3'd7, 2'b00}), 0, 0);
        exec_instr(enc(OP_ADDI, 3'd6, 3'd3, 5'd16), 0, 0);
        exec_instr(enc(OP_SRI,  3'd2, 3'd5, 5'd1), 0, 0);
        exec_instr(enc(OP_NOT,  3'd3, 3'd3, 5'd0), 0, 0);
        exec_instr(enc(OP_LOAD, 3'd7, 3'd0, 5'd30), 3, 2);
        d_ae = n_ae;
        exec_instr(enc(OP_NOP,  3'd1, 3'd1, 5'd1), 0, 0);
        exec_instr(enc(5'h15,   3'd2, 3'd2, 5'd2), 1, 0);
        @(negedge clock); #1;
        chk("nop_unrec_ae_cycles", 32'(n_ae - d_ae), 32'd0);

        do_reset(2);
        exec_instr(enc(OP_OR, 3'd1, 3'd2, {3'd3, 2'b00}), 0, 0);
        @(negedge clock); #1;
        chk("refetch_pc", 32'(pc_out), 32'd1);

        preset_pc_ffff();
        exec_instr(enc(OP_NOP, 3'd0, 3'd0, 5'd0), 0, 0);
        @(negedge clock); #1;
        chk("wrap_pc", 32'(pc_out), 32'd0);
        exec_instr(enc(5'h1E, 3'd5, 3'd5, 5'd9), 1, 0);

        exec_instr(enc(OP_HALT, 3'd0, 3'd0, 5'd0), 0, 0);
        @(negedge clock); #1;
        d_ae = n_ae; d_rw = n_rw; d_mr = n_mr; d_mw = n_mw;
        halt_cycles(20);
        @(negedge clock); #1;
        chk("halt_flag", 32'(halted), 32'd1);
        chk("halt_pc", 32'(pc_out), 32'd2);
        chk("halt_strobes", 32'((n_ae - d_ae) + (n_rw - d_rw) + (n_mr - d_mr) + (n_mw - d_mw)), 32'd0);

        do_reset(0);
        exec_instr(enc(OP_SL, 3'd6, 3'd7, {3'd1, 2'b00}), 1, 0);
        @(negedge clock); #1;
        chk("final_pc", 32'(pc_out), 32'd1);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 Parameter WORD_SIZE, default 16, datapath/instruction width (from parameters.vh).
REQ-002 Parameter REG_ADDR_BITS, default 3, register-file address width.
REQ-003 Clock and reset: one clock; reset is asynchronous and active-high; ports named clock and reset.
REQ-004 clock  input  1  rising-edge system clock.
REQ-005 reset  input  1  asynchronous active-high reset.
REQ-006 instr_in  input  WORD_SIZE  instruction word returned by memory.
REQ-007 mem_ready  input  1  memory completes current read/write this cycle.
REQ-008 mem_read  output  1  memory read request.
REQ-009 mem_write  output  1  memory write request.
REQ-010 mem_addr_sel  output  1  0 = address from pc_out, 1 = address from ALU result.
REQ-011 pc_out  output  WORD_SIZE  program counter.
REQ-012 opcode  output  5  opcode presented to ALU.
REQ-013 alu_enable  output  1  single-cycle ALU strobe.
REQ-014 rs1_addr, rs2_addr, rd_addr  output  REG_ADDR_BITS each  register-file addresses.
REQ-015 imm_out  output  WORD_SIZE  zero-extended 5-bit immediate.
REQ-016 alu_src_imm  output  1  ALU input2 from imm_out, not rs2.
REQ-017 reg_write  output  1  register-file write strobe.
REQ-018 wb_sel  output  1  write-back source: 0 = ALU, 1 = memory.
REQ-019 halted  output  1  core stopped.

Function
REQ-020 Instruction fields: opcode [15:11], rd [10:8], rs1 [7:5], rs2 [4:2], imm5 [4:0]; latched in instruction register (IR).
REQ-021 FSM states: FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, HALT.
REQ-022 FETCH: mem_read=1, mem_addr_sel=0; held until mem_ready; on mem_ready, IR<=instr_in, PC<=PC+1, next DECODE.
REQ-023 DECODE: HALT opcode -> HALT; NOP or unrecognised opcode -> FETCH without any strobe; all others -> EXECUTE.
REQ-024 EXECUTE: alu_enable=1 exactly one cycle; opcode = IR opcode, except LOAD/STORE drive ADD (address = rs1 + imm).
REQ-025 alu_src_imm=1 for ANDI, ADDI, SRI, SLI, LOAD, STORE; 0 otherwise.
REQ-026 EXECUTE next: LOAD/STORE -> MEMORY; else WRITEBACK.
REQ-027 MEMORY: mem_addr_sel=1; LOAD asserts mem_read, STORE asserts mem_write; held until mem_ready; LOAD -> WRITEBACK, STORE -> FETCH.
REQ-028 WRITEBACK: reg_write=1 one cycle; wb_sel=1 for LOAD, else 0; next FETCH.
REQ-029 opcode, rs*/rd, imm_out driven from IR; stable DECODE through WRITEBACK.
REQ-030 mem_read and mem_write never asserted simultaneously; mem_ready ignored outside FETCH/MEMORY.
REQ-031 Latency with mem_ready=1 every request: ALU op 4 cycles, LOAD 5, STORE 4, NOP 2.
REQ-032 PC wraps from 2^WORD_SIZE-1 to 0.
REQ-033 HALT: sticky; halted=1; all strobes 0; PC frozen; exit only via reset.

Reset
REQ-034 On reset assertion, state=FETCH, PC=0, IR=0, all strobes and halted=0, without waiting for clock.
REQ-035 Reset mid-transaction aborts it; mem_read/mem_write drop immediately; first post-reset fetch uses address 0.
REQ-036 Reset deassertion: mem_read asserts on the first clock after release.

Structure
REQ-037 Opcode macros, field bit positions, and state encodings belong in shared parameters.vh.
REQ-038 One sub-module, program_counter (increment, wrap, freeze, async reset), is instantiated.

Verification
REQ-039 Reset then ADD rd=3 rs1=1 rs2=2, mem_ready=1 -> alu_enable in cycle 3, opcode=ADD, reg_write cycle 4, wb_sel=0, pc_out=1.
REQ-040 LOAD rd=2 rs1=1 imm=5 -> alu_enable with opcode=ADD, alu_src_imm=1, imm_out=5; MEMORY mem_read=1, mem_addr_sel=1; reg_write with wb_sel=1.
REQ-041 STORE with mem_ready withheld 3 cycles in MEMORY -> mem_write held 4 cycles, no reg_write, then FETCH.
REQ-042 Reset pulse during FETCH wait (mem_ready=0) -> mem_read drops same cycle, pc_out=0, refetch from 0.
REQ-043 HALT opcode -> halted=1 after DECODE; 20 further cycles with mem_ready=1 -> no strobes, pc_out unchanged.
REQ-044 PC preset to 0xFFFF, NOP fetched -> pc_out=0x0000; unrecognised opcode behaves as NOP.
